// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit scheduler slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BUSY  = 2'b10,
        GAP   = 2'b11
    } sched_state_t;

    localparam int BYTE_W = 8;

    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    // Scan upward from the pointer and keep only the first hit.
    always_comb begin
        int   idx_s;
        logic hit_s;
        grant = '0;
        valid = 1'b0;
        idx_s = 0;
        hit_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = int'(ptr) + k;
            idx_s = (idx_s >= N_REQ) ? idx_s - N_REQ : idx_s;
            hit_s = ~valid & (|(req & (ONE_HOT0 << idx_s)));
            grant = hit_s ? idx_s[IW-1:0] : grant;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers,
// with per-frame start/done sequencing, inter-frame gap and a done watchdog.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 262143
) (
    input  logic                     clk,
    input  logic                     Tx_rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [BYTE_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     Start,
    output logic [BYTE_W-1:0]        data,
    input  logic                     done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int IW = clog2_min1(N_REQ);
    localparam int GW = clog2_min1(GAP_CYCLES + 1);
    localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);

    localparam logic [GW-1:0]    GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [TW-1:0]    WD_LAST  = (TIMEOUT_CYCLES > 1) ? TW'(TIMEOUT_CYCLES - 1) : TW'(1'b1);
    localparam logic [N_REQ-1:0] ACK_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    PTR_LAST = IW'(N_REQ - 1);

    sched_state_t      state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     grant_id_r, grant_id_s;
    logic [BYTE_W-1:0] data_r, data_s;
    logic              start_r, start_s;
    logic [N_REQ-1:0]  ack_r, ack_s;
    logic              timeout_err_r, timeout_err_s;
    logic              busy_r, busy_s;
    logic              done_q_r;
    logic [GW-1:0]     gap_cnt_r, gap_cnt_s;
    logic [TW-1:0]     wdog_r, wdog_s;

    logic              done_rise_s;
    logic [N_REQ-1:0]  req_eff_s;
    logic [IW-1:0]     arb_grant_s;
    logic              arb_valid_s;
    logic [BYTE_W-1:0] sel_data_s;
    logic [IW-1:0]     next_ptr_s;
    logic [TW-1:0]     wdog_inc_s;
    logic              timeout_hit_s;

    // A requester still seeing its own ack pulse must not be re-granted.
    assign req_eff_s     = req & ~ack_r;
    assign done_rise_s   = done & ~done_q_r;
    assign next_ptr_s    = (grant_id_r == PTR_LAST) ? '0 : grant_id_r + IW'(1'b1);
    assign wdog_inc_s    = wdog_r + TW'(1'b1);
    assign timeout_hit_s = (wdog_inc_s == WD_LAST);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req   (req_eff_s),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    // Byte mux for the requester the arbiter is currently pointing at.
    always_comb begin
        sel_data_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            sel_data_s = (arb_grant_s == IW'(j)) ? req_data[BYTE_W*j +: BYTE_W] : sel_data_s;
        end
    end

    // Frame sequencer: next state and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        grant_id_s    = grant_id_r;
        data_s        = data_r;
        start_s       = 1'b0;
        ack_s         = '0;
        timeout_err_s = 1'b0;
        gap_cnt_s     = gap_cnt_r;
        wdog_s        = wdog_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    grant_id_s = arb_grant_s;
                    data_s     = sel_data_s;
                    start_s    = 1'b1;
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                wdog_s  = '0;
                state_s = BUSY;
            end
            BUSY: begin
                if (done_rise_s || timeout_hit_s) begin
                    ack_s         = ACK_ONE << grant_id_r;
                    timeout_err_s = ~done_rise_s;
                    ptr_s         = next_ptr_s;
                    gap_cnt_s     = '0;
                    state_s       = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    wdog_s = wdog_inc_s;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; Tx_rst clears everything immediately.
    always_ff @(posedge clk or negedge Tx_rst) begin
        if (!Tx_rst) begin
            state_r       <= IDLE;
            ptr_r         <= '0;
            grant_id_r    <= '0;
            data_r        <= 8'h00;
            start_r       <= 1'b0;
            ack_r         <= '0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
            done_q_r      <= 1'b0;
            gap_cnt_r     <= '0;
            wdog_r        <= '0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            grant_id_r    <= grant_id_s;
            data_r        <= data_s;
            start_r       <= start_s;
            ack_r         <= ack_s;
            timeout_err_r <= timeout_err_s;
            busy_r        <= busy_s;
            done_q_r      <= done;
            gap_cnt_r     <= gap_cnt_s;
            wdog_r        <= wdog_s;
        end
    end

    assign ack         = ack_r;
    assign Start       = start_r;
    assign data        = data_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: frame table plus ack scoreboard, with hand-written
// stale-done and mid-frame reset sequences.
module tb_uart_tx_scheduler;

    localparam int TB_GAP     = 16;
    localparam int TB_TIMEOUT = 100;

    typedef struct {
        logic [1:0] g;
        logic [7:0] b;
        logic       to;
    } exp_t;

    typedef struct {
        logic [3:0] req_v;
        int         delay;
        logic       rel;
        logic       drop;
        logic [1:0] g;
        logic [7:0] b;
        logic       to;
    } frame_t;

    logic        clk = 1'b0;
    logic        Tx_rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        Start;
    logic [7:0]  data;
    logic        done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;
    frame_t tbl[10];

    uart_tx_scheduler #(
        .N_REQ          (4),
        .GAP_CYCLES     (TB_GAP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .Tx_rst      (Tx_rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .Start       (Start),
        .data        (data),
        .done        (done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (Tx_rst === 1'b1 && ack !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_onehot", {28'd0, ack}, {28'd0, 4'b0001 << mon_e.g});
                check("ack_data", {24'd0, data}, {24'd0, mon_e.b});
                check("ack_grant", {30'd0, grant_id}, {30'd0, mon_e.g});
                check("ack_timeout", {31'd0, timeout_err}, {31'd0, mon_e.to});
            end
        end
    end

    task automatic wait_start();
        int n;
        n = 0;
        while (Start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic serve(input frame_t f);
        int   n;
        int   t0;
        exp_t e;
        e.g = f.g;
        e.b = f.b;
        e.to = f.to;
        req = f.req_v;
        exp_q.push_back(e);
        wait_start();
        check("start_seen", {31'd0, Start}, 32'd1);
        check("start_data", {24'd0, data}, {24'd0, f.b});
        check("start_grant", {30'd0, grant_id}, {30'd0, f.g});
        t0 = cyc;
        @(negedge clk);
        check("start_width", {31'd0, Start}, 32'd0);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        if (f.drop) req[f.g] = 1'b0;
        if (f.delay >= 0) begin
            repeat (f.delay) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
        n = 0;
        while (ack === 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", {31'd0, (ack !== 4'b0000)}, 32'd1);
        check("ack_latency", cyc - t0, (f.delay >= 0) ? f.delay + 2 : TB_TIMEOUT);
        if (f.rel) req[f.g] = 1'b0;
        @(negedge clk);
        check("ack_width", {28'd0, ack}, 32'd0);
        check("timeout_width", {31'd0, timeout_err}, 32'd0);
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gap_length", n, TB_GAP);
    endtask

    initial begin
        logic   seen;
        int     n;
        exp_t   e;
        frame_t f;

        tbl[0] = '{4'b1111, 20, 1'b0, 1'b0, 2'd0, 8'h10, 1'b0};
        tbl[1] = '{4'b1111, 20, 1'b0, 1'b0, 2'd1, 8'h21, 1'b0};
        tbl[2] = '{4'b1111, 20, 1'b0, 1'b0, 2'd2, 8'h32, 1'b0};
        tbl[3] = '{4'b1111, 20, 1'b0, 1'b0, 2'd3, 8'h43, 1'b0};
        tbl[4] = '{4'b1111, 20, 1'b0, 1'b0, 2'd0, 8'h10, 1'b0};
        tbl[5] = '{4'b0100, 20, 1'b1, 1'b0, 2'd2, 8'h32, 1'b0};
        tbl[6] = '{4'b1001, 20, 1'b1, 1'b0, 2'd3, 8'h43, 1'b0};
        tbl[7] = '{4'b0001, 20, 1'b1, 1'b0, 2'd0, 8'h10, 1'b0};
        tbl[8] = '{4'b0010, -1, 1'b1, 1'b0, 2'd1, 8'h21, 1'b1};
        tbl[9] = '{4'b0100, 25, 1'b1, 1'b1, 2'd2, 8'h32, 1'b0};

        Tx_rst   = 1'b0;
        req      = 4'b0000;
        done     = 1'b0;
        req_data = 32'h4332_21A5;
        repeat (3) @(negedge clk);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_start", {31'd0, Start}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        Tx_rst = 1'b1;

        f = '{4'b0001, 50, 1'b1, 1'b0, 2'd0, 8'hA5, 1'b0};
        serve(f);

        Tx_rst = 1'b0;
        repeat (2) @(negedge clk);
        req_data = 32'h4332_2110;
        Tx_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            serve(tbl[i]);
        end

        // Stale done: high before Start must not complete the frame.
        req  = 4'b0001;
        done = 1'b1;
        e.g = 2'd0;
        e.b = 8'h10;
        e.to = 1'b0;
        exp_q.push_back(e);
        wait_start();
        check("stale_start", {31'd0, Start}, 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | (ack !== 4'b0000);
        end
        check("stale_no_ack", {31'd0, seen}, 32'd0);
        done = 1'b0;
        repeat (30) @(negedge clk);
        done = 1'b1;
        n = 0;
        while (ack === 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stale_fresh_ack", {28'd0, ack}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        done = 1'b0;
        check("stale_single_ack", {28'd0, ack}, 32'd0);
        wait_idle();

        // Reset mid-BUSY: outputs clear between clock edges, no ack, pointer back to 0.
        req = 4'b0101;
        wait_start();
        check("rstmid_grant", {30'd0, grant_id}, 32'd2);
        repeat (5) @(negedge clk);
        #2 Tx_rst = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_start", {31'd0, Start}, 32'd0);
        check("rstmid_data", {24'd0, data}, 32'd0);
        check("rstmid_grant0", {30'd0, grant_id}, 32'd0);
        check("rstmid_ack", {28'd0, ack}, 32'd0);
        check("rstmid_timeout", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        Tx_rst = 1'b1;
        f = '{4'b0101, 15, 1'b1, 1'b0, 2'd0, 8'h10, 1'b0};
        serve(f);
        f = '{4'b0100, 10, 1'b1, 1'b0, 2'd2, 8'h32, 1'b0};
        serve(f);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART Transmitter among N_REQ byte producers using round-robin arbitration.
- Sequences each frame: latches the winner's byte, pulses Start, waits for the Transmitter's done, acks the winner, then enforces an inter-frame idle gap.
- Sits between on-chip byte sources and the Transmitter's Start/data/done interface. The Reciever2/syncronizer path is unaffected.
- Includes a watchdog so that a lost done cannot hang the link.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles inserted after each frame; 0 means no gap.
- TIMEOUT_CYCLES, 262143, maximum clk cycles in BUSY waiting for done before abort.

Ports:
- clk  input  1  system clock.
- Tx_rst  input  1  reset, asynchronous assert, active-low.
- req  input  N_REQ  per-requester level request; held until its ack.
- req_data  input  8*N_REQ  byte for requester i on bits [8i+7:8i]; stable while req[i]=1.
- ack  output  N_REQ  one-cycle pulse to the served requester at frame end.
- Start  output  1  one-cycle start pulse to the Transmitter.
- data  output  8  byte to the Transmitter; held stable from Start until the frame ends.
- done  input  1  Transmitter completion; only its rising edge is used.
- busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(N_REQ)  index of the current/last granted requester.
- timeout_err  output  1  one-cycle pulse when the watchdog aborts a frame.

Behaviour:
Reset (Tx_rst=0, async):
- state=IDLE; Start=0; ack=0; data=8'h00; grant_id=0; timeout_err=0; busy=0.
- RR pointer=0; gap/watchdog counters=0; done_q=0.

Clocking and done handling:
- All state updates on the rising edge of clk.
- done_q registers done every cycle; done_rise = done & ~done_q.

States: IDLE, START, BUSY, GAP.
- IDLE, when |req:
  - Pick the first set req at or after the RR pointer, wrapping modulo N_REQ.
  - Latch grant_id and data=req_data[grant].
  - Start<=1; go to START.
  - Latency: req seen at edge k gives Start=1 during cycle k..k+1.
- START:
  - Start<=0; clear watchdog; go to BUSY.
  - Start is high for exactly one cycle.
- BUSY:
  - Watchdog increments each cycle.
  - On done_rise: ack[grant_id]<=1 for one cycle; RR pointer<=(grant_id+1) mod N_REQ; go to GAP, or to IDLE if GAP_CYCLES=0.
  - Watchdog reaching TIMEOUT_CYCLES-1 without done_rise: ack[grant_id]<=1 and timeout_err<=1 for one cycle; same pointer update and exit.
  - If done_rise and timeout occur in the same cycle, done wins and timeout_err stays 0.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Requests are ignored during GAP.

Boundary rules:
- A done_rise outside BUSY is ignored.
- A done already high on entry to BUSY (stale) does not complete the frame; a fresh rising edge is required.
- req[i] dropped before grant: not served, no ack.
- req[i] dropped after grant: frame still completes with the latched data, and ack is still pulsed.
- The same requester is never granted twice in a row while another req is pending (round-robin fairness).
- Ack pulses are one-hot; at most one ack per frame.
- Counters saturate and never wrap.
- Tx_rst asserted mid-frame: immediate return to reset values. The Transmitter shares Tx_rst, so no partial frame resumes.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, BUSY, GAP} sched_state_t.
  - localparam BYTE_W=8.
  - Widths helper function clog2_min1.
- Sub-module rr_arbiter (combinational): inputs req and pointer, outputs grant index and valid.
  - The pointer register stays in uart_tx_scheduler.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5 → Start pulses 1 cycle after req, data=8'hA5; done pulse 50 cycles later → ack=4'b0001 one cycle later, busy low after 16 GAP cycles.
- Fairness: req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 → grant order 0,1,2,3,0; each ack matches its byte on data.
- Pointer wrap: pointer=3 after serving 2, req=4'b1001 → grant 3, then 0.
- Watchdog: TIMEOUT_CYCLES=100, done held 0 → at cycle 100 of BUSY ack[grant] and timeout_err pulse together; next request proceeds normally.
- Stale done: done held 1 before Start → no completion; done falls then rises 30 cycles later → single ack.
- Reset mid-BUSY: Tx_rst low for 2 cycles → all outputs at reset values asynchronously; no ack; the pending req is served from pointer 0 after release.
